// File: rtl/rob_rollback_ctrl.sv
// ROB rollback sequencer: walks youngest->branch+1 undoing rename state, then resets tail.
// Optional perf counters enabled by defining ROB_ROLLBACK_PERF_EN.
module rob_rollback_ctrl #(
   parameter int unsigned ROB_SIZE   = 32,
   parameter int unsigned PHYS_IDX_W = 6,
   parameter int unsigned ARCH_IDX_W = 5,
   localparam int unsigned IDX_W     = $clog2(ROB_SIZE)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  mispredict_valid,
   input  logic [IDX_W-1:0]      mispredict_rob_idx,
   input  logic [IDX_W-1:0]      rob_tail,
   output logic [IDX_W-1:0]      rd_idx,
   input  logic                  rd_busy,
   input  logic                  rd_has_dest,
   input  logic [ARCH_IDX_W-1:0] rd_arch_dest,
   input  logic [PHYS_IDX_W-1:0] rd_T_old,
   input  logic [PHYS_IDX_W-1:0] rd_T_new,
   output logic                  undo_valid,
   output logic [ARCH_IDX_W-1:0] undo_arch_reg,
   output logic [PHYS_IDX_W-1:0] undo_T_old,
   output logic [PHYS_IDX_W-1:0] undo_T_new,
   output logic                  squash_valid,
   output logic [IDX_W-1:0]      squash_idx,
   output logic                  tail_set_valid,
   output logic [IDX_W-1:0]      tail_set_value,
   output logic                  stall,
`ifdef ROB_ROLLBACK_PERF_EN
   output logic [31:0]           perf_rollbacks,
   output logic [31:0]           perf_walk_cycles,
`endif
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WALK   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] br_idx_q, br_idx_d;
   logic [IDX_W-1:0] cur_q, cur_d;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         br_idx_q <= '0;
         cur_q    <= '0;
      end else begin
         state_q  <= state_d;
         br_idx_q <= br_idx_d;
         cur_q    <= cur_d;
      end
   end

   // Next state and outputs
   always_comb begin
      state_d        = state_q;
      br_idx_d       = br_idx_q;
      cur_d          = cur_q;
      rd_idx         = '0;
      undo_valid     = 1'b0;
      undo_arch_reg  = '0;
      undo_T_old     = '0;
      undo_T_new     = '0;
      squash_valid   = 1'b0;
      squash_idx     = '0;
      tail_set_valid = 1'b0;
      tail_set_value = '0;
      stall          = 1'b0;
      done           = 1'b0;
      case (state_q)
         IDLE: begin
            stall = mispredict_valid;
            if (mispredict_valid) begin
               br_idx_d = mispredict_rob_idx;
               cur_d    = rob_tail;
               state_d  = (rob_tail == mispredict_rob_idx) ? FINISH : WALK;
            end
         end
         WALK: begin
            stall         = 1'b1;
            rd_idx        = cur_q;
            squash_valid  = 1'b1;
            squash_idx    = cur_q;
            undo_valid    = rd_busy & rd_has_dest;
            undo_arch_reg = rd_arch_dest;
            undo_T_old    = rd_T_old;
            undo_T_new    = rd_T_new;
            // Stop after the entry just younger than the branch; decrement wraps naturally
            if (cur_q == IDX_W'(br_idx_q + IDX_W'(1))) begin
               state_d = FINISH;
            end else begin
               cur_d = IDX_W'(cur_q - IDX_W'(1));
            end
         end
         FINISH: begin
            stall          = 1'b1;
            tail_set_valid = 1'b1;
            tail_set_value = br_idx_q;
            done           = 1'b1;
            state_d        = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef ROB_ROLLBACK_PERF_EN
   logic [31:0] perf_rollbacks_q;
   logic [31:0] perf_walk_cycles_q;

   // Saturating performance counters
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_rollbacks_q   <= '0;
         perf_walk_cycles_q <= '0;
      end else begin
         if (state_q == IDLE && mispredict_valid && perf_rollbacks_q != 32'hFFFF_FFFF) begin
            perf_rollbacks_q <= perf_rollbacks_q + 32'd1;
         end
         if (state_q == WALK && perf_walk_cycles_q != 32'hFFFF_FFFF) begin
            perf_walk_cycles_q <= perf_walk_cycles_q + 32'd1;
         end
      end
   end

   assign perf_rollbacks   = perf_rollbacks_q;
   assign perf_walk_cycles = perf_walk_cycles_q;
`endif

endmodule

// File: tb/tb_rob_rollback_ctrl.sv
// Scoreboard bench for rob_rollback_ctrl: directed rollbacks, wrap, empty walk, no-dest, reset abort.
module tb_rob_rollback_ctrl;

   typedef struct packed {
      logic       sq;
      logic [4:0] sq_idx;
      logic       uv;
      logic [4:0] arch;
      logic [5:0] told;
      logic [5:0] tnew;
      logic       ts;
      logic [4:0] tsv;
      logic       dn;
   } ev_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       mispredict_valid;
   logic [4:0] mispredict_rob_idx;
   logic [4:0] rob_tail;
   logic [4:0] rd_idx;
   logic       rd_busy, rd_has_dest;
   logic [4:0] rd_arch_dest;
   logic [5:0] rd_T_old, rd_T_new;
   logic       undo_valid;
   logic [4:0] undo_arch_reg;
   logic [5:0] undo_T_old, undo_T_new;
   logic       squash_valid;
   logic [4:0] squash_idx;
   logic       tail_set_valid;
   logic [4:0] tail_set_value;
   logic       stall, done;
`ifdef ROB_ROLLBACK_PERF_EN
   logic [31:0] perf_rollbacks, perf_walk_cycles;
`endif

   logic       rob_busy [32];
   logic       rob_has_dest [32];
   logic [4:0] rob_arch [32];
   logic [5:0] rob_told [32];
   logic [5:0] rob_tnew [32];

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  stall_cnt = 0;
   logic in_recovery = 1'b0;

   always #5 clock = ~clock;

   rob_rollback_ctrl dut (
      .clock(clock), .reset(reset),
      .mispredict_valid(mispredict_valid), .mispredict_rob_idx(mispredict_rob_idx),
      .rob_tail(rob_tail), .rd_idx(rd_idx), .rd_busy(rd_busy), .rd_has_dest(rd_has_dest),
      .rd_arch_dest(rd_arch_dest), .rd_T_old(rd_T_old), .rd_T_new(rd_T_new),
      .undo_valid(undo_valid), .undo_arch_reg(undo_arch_reg),
      .undo_T_old(undo_T_old), .undo_T_new(undo_T_new),
      .squash_valid(squash_valid), .squash_idx(squash_idx),
      .tail_set_valid(tail_set_valid), .tail_set_value(tail_set_value),
      .stall(stall),
`ifdef ROB_ROLLBACK_PERF_EN
      .perf_rollbacks(perf_rollbacks), .perf_walk_cycles(perf_walk_cycles),
`endif
      .done(done)
   );

   // ROB model: combinational read port, entry i holds arch=31-i, T_old=i+1, T_new=i+32
   assign rd_busy      = rob_busy[rd_idx];
   assign rd_has_dest  = rob_has_dest[rd_idx];
   assign rd_arch_dest = rob_arch[rd_idx];
   assign rd_T_old     = rob_told[rd_idx];
   assign rd_T_new     = rob_tnew[rd_idx];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic void push_squash(input logic [4:0] idx, input logic uv, input logic [4:0] arch,
                                       input logic [5:0] told, input logic [5:0] tnew);
      ev_t e;
      e = '0;
      e.sq = 1'b1; e.sq_idx = idx; e.uv = uv;
      e.arch = arch; e.told = told; e.tnew = tnew;
      exp_q.push_back(e);
   endfunction

   function automatic void push_finish(input logic [4:0] br);
      ev_t e;
      e = '0;
      e.ts = 1'b1; e.tsv = br; e.dn = 1'b1;
      exp_q.push_back(e);
   endfunction

   // Upstream contract: no new mispredict while a recovery is in flight
   always @(posedge clock) begin
      if (!reset) assert (!(mispredict_valid && in_recovery))
         else $error("mispredict presented during recovery");
   end

   // Monitor: pop and compare whenever the DUT presents a squash/undo/tail/done
   always @(negedge clock) begin
      ev_t obs, e;
      if (stall && !mispredict_valid) stall_cnt++;
      if (squash_valid || undo_valid || tail_set_valid || done) begin
         obs = '{sq: squash_valid, sq_idx: squash_idx, uv: undo_valid, arch: undo_arch_reg,
                 told: undo_T_old, tnew: undo_T_new, ts: tail_set_valid, tsv: tail_set_value, dn: done};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %h expected none", obs);
         end else begin
            e = exp_q.pop_front();
            if (!e.uv) begin
               obs.arch = e.arch; obs.told = e.told; obs.tnew = e.tnew;
            end
            if (obs !== e) begin
               errors++;
               $display("FAIL event: got %h expected %h", obs, e);
            end
         end
      end
   end

   task automatic issue(input logic [4:0] br, input logic [4:0] tail);
      @(posedge clock); #1;
      mispredict_valid = 1'b1; mispredict_rob_idx = br; rob_tail = tail;
      @(negedge clock);
      check("idle_comb_stall", 32'(stall), 32'd1);
      @(posedge clock); #1;
      mispredict_valid = 1'b0;
      in_recovery = 1'b1;
   endtask

   task automatic wait_done(input int max_cycles);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         @(negedge clock);
         if (done) seen = 1'b1;
      end
      if (!seen) check("done_timeout", 32'd0, 32'd1);
      @(negedge clock);
      in_recovery = 1'b0;
   endtask

   task automatic run(input string name, input logic [4:0] br, input logic [4:0] tail, input int exp_stall);
      stall_cnt = 0;
      issue(br, tail);
      wait_done(40);
      check({name, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
      check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rob_busy[i]     = 1'b1;
         rob_has_dest[i] = 1'b1;
         rob_arch[i]     = 5'(31 - i);
         rob_told[i]     = 6'(i + 1);
         rob_tnew[i]     = 6'(i + 32);
      end
      reset = 1'b1; mispredict_valid = 1'b0; mispredict_rob_idx = '0; rob_tail = '0;

      // 1: reset
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_undo_valid", 32'(undo_valid), 32'd0);
      check("rst_squash_valid", 32'(squash_valid), 32'd0);
      check("rst_tail_set_valid", 32'(tail_set_valid), 32'd0);
      check("rst_tail_set_value", 32'(tail_set_value), 32'd0);
      check("rst_rd_idx", 32'(rd_idx), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // 2: branch 5, tail 8
      push_squash(5'd8, 1'b1, 5'd23, 6'd9, 6'd40);
      push_squash(5'd7, 1'b1, 5'd24, 6'd8, 6'd39);
      push_squash(5'd6, 1'b1, 5'd25, 6'd7, 6'd38);
      push_finish(5'd5);
      run("basic", 5'd5, 5'd8, 4);

      // 3: wrap across index 0
      push_squash(5'd1, 1'b1, 5'd30, 6'd2, 6'd33);
      push_squash(5'd0, 1'b1, 5'd31, 6'd1, 6'd32);
      push_squash(5'd31, 1'b1, 5'd0, 6'd32, 6'd63);
      push_finish(5'd30);
      run("wrap", 5'd30, 5'd1, 4);

      // 4: branch is youngest, nothing to walk
      push_finish(5'd12);
      run("empty", 5'd12, 5'd12, 1);

      // 5: entry 7 has no destination
      rob_has_dest[7] = 1'b0;
      push_squash(5'd8, 1'b1, 5'd23, 6'd9, 6'd40);
      push_squash(5'd7, 1'b0, 5'd0, 6'd0, 6'd0);
      push_squash(5'd6, 1'b1, 5'd25, 6'd7, 6'd38);
      push_finish(5'd5);
      run("nodest", 5'd5, 5'd8, 4);
      rob_has_dest[7] = 1'b1;

      // 6: reset during second WALK cycle aborts recovery
      push_squash(5'd8, 1'b1, 5'd23, 6'd9, 6'd40);
      push_squash(5'd7, 1'b1, 5'd24, 6'd8, 6'd39);
      issue(5'd5, 5'd8);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      in_recovery = 1'b0;
      @(negedge clock);
      check("abort_stall", 32'(stall), 32'd0);
      check("abort_squash", 32'(squash_valid), 32'd0);
      begin
         int pulses;
         pulses = 0;
         repeat (6) begin
            @(negedge clock);
            if (done || tail_set_valid) pulses++;
         end
         check("abort_no_done", 32'(pulses), 32'd0);
      end
      check("abort_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
